// File: rtl/io_bridge_pio.sv
// io_bridge_pio: Avalon-MM slave bridging software to game hardware.
//   - keycode FIFO pushed by software, popped by a valid/ready consumer
//   - hex-digit display register
//   - debounced push-buttons with press-edge capture and a maskable IRQ
// Optional build macro: IOB_RELEASE_EDGE_EN adds release-edge capture
// (KEYS register bits [24+:NUM_KEYS]) and lets release edges raise irq.
module io_bridge_pio #(
  parameter int KEYCODE_W       = 8,
  parameter int HEX_W           = 16,
  parameter int NUM_KEYS        = 2,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [NUM_KEYS-1:0]  key_in,
  output logic [KEYCODE_W-1:0] keycode_export,
  output logic                 keycode_valid,
  input  logic                 keycode_ready,
  output logic [HEX_W-1:0]     hex_digits_export
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // ---------------------------------------------------------------------
  // Write qualification: the first clock after reset release ignores writes
  // ---------------------------------------------------------------------
  logic init_done;
  logic wr_en;
  logic wr_keycode;
  logic wr_status;
  logic wr_hex;
  logic wr_keys;

  // Marks the end of the reset-release cycle so writes in it are dropped
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  assign wr_en      = avs_write & init_done;
  assign wr_keycode = wr_en & (avs_address == 2'd0);
  assign wr_status  = wr_en & (avs_address == 2'd1);
  assign wr_hex     = wr_en & (avs_address == 2'd2);
  assign wr_keys    = wr_en & (avs_address == 2'd3);

  // ---------------------------------------------------------------------
  // Keycode FIFO
  // ---------------------------------------------------------------------
  logic [KEYCODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push_ok;
  logic                 ovf_set;

  assign fifo_empty     = (count == {CNT_W{1'b0}});
  assign fifo_full      = (count == CNT_W'(FIFO_DEPTH));
  assign keycode_valid  = ~fifo_empty;
  assign keycode_export = mem[rd_ptr];
  assign pop            = keycode_valid & keycode_ready;
  // A pop in the same cycle frees the slot the push needs
  assign push_ok        = wr_keycode & (~fifo_full | pop);
  assign ovf_set        = wr_keycode & fifo_full & ~pop;

  // FIFO storage, pointers (wrap naturally, depth is a power of two) and count
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= {KEYCODE_W{1'b0}};
      end
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= avs_writedata[KEYCODE_W-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a same-cycle clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (wr_status && avs_writedata[2]) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  // ---------------------------------------------------------------------
  // Hex display register
  // ---------------------------------------------------------------------
  logic [HEX_W-1:0] hex_reg;

  // Software-written hex display value
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hex_reg <= {HEX_W{1'b0}};
    end else if (wr_hex) begin
      hex_reg <= avs_writedata[HEX_W-1:0];
    end else begin
      hex_reg <= hex_reg;
    end
  end

  assign hex_digits_export = hex_reg;

  // ---------------------------------------------------------------------
  // Key synchroniser, debounce and edge capture
  // ---------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] pressed_sync;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_next;
  logic [DB_W-1:0]     db_cnt      [NUM_KEYS];
  logic [DB_W-1:0]     db_cnt_next [NUM_KEYS];
  logic [NUM_KEYS-1:0] press_set;
  logic [NUM_KEYS-1:0] press_edges;
  logic [NUM_KEYS-1:0] irq_mask;
  logic [NUM_KEYS-1:0] edge_w1c;
  logic [NUM_KEYS-1:0] irq_src;

  // Two-flop synchroniser for the raw active-low buttons (released = 1)
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= {NUM_KEYS{1'b1}};
      sync2 <= {NUM_KEYS{1'b1}};
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pressed_sync = ~sync2;

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_next[i] = {DB_W{1'b0}};
      if (pressed_sync[i] != stable[i]) begin
        if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_next[i] = pressed_sync[i];
        end else begin
          db_cnt_next[i] = db_cnt[i] + 1'b1;
        end
      end else begin
        db_cnt_next[i] = {DB_W{1'b0}};
      end
    end
  end

  // Debounced level and per-key counters
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable <= {NUM_KEYS{1'b0}};
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= {DB_W{1'b0}};
      end
    end else begin
      stable <= stable_next;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= db_cnt_next[i];
      end
    end
  end

  assign press_set = stable_next & ~stable;
  assign edge_w1c  = wr_keys ? avs_writedata[16 +: NUM_KEYS] : {NUM_KEYS{1'b0}};

  // Press-edge capture (a set beats a same-cycle clear) and irq mask
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      press_edges <= {NUM_KEYS{1'b0}};
      irq_mask    <= {NUM_KEYS{1'b0}};
    end else begin
      press_edges <= (press_edges & ~edge_w1c) | press_set;
      if (wr_keys) begin
        irq_mask <= avs_writedata[8 +: NUM_KEYS];
      end else begin
        irq_mask <= irq_mask;
      end
    end
  end

`ifdef IOB_RELEASE_EDGE_EN
  logic [NUM_KEYS-1:0] release_set;
  logic [NUM_KEYS-1:0] release_edges;

  assign release_set = ~stable_next & stable;

  // Release-edge capture, same write-1-to-clear bits as press edges
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      release_edges <= {NUM_KEYS{1'b0}};
    end else begin
      release_edges <= (release_edges & ~edge_w1c) | release_set;
    end
  end

  assign irq_src = (press_edges | release_edges) & irq_mask;
`else
  assign irq_src = press_edges & irq_mask;
`endif

  // Registered level interrupt
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |irq_src;
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [31:0] rdata_next;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Register map read mux, zero-extended
  always_comb begin
    rdata_next = 32'd0;
    case (avs_address)
      2'd0: rdata_next[KEYCODE_W-1:0] = keycode_export;
      2'd1: begin
        rdata_next[0]          = fifo_empty;
        rdata_next[1]          = fifo_full;
        rdata_next[2]          = overflow;
        rdata_next[8 +: CNT_W] = count;
      end
      2'd2: rdata_next[HEX_W-1:0] = hex_reg;
      2'd3: begin
        rdata_next[0  +: NUM_KEYS] = stable;
        rdata_next[8  +: NUM_KEYS] = irq_mask;
        rdata_next[16 +: NUM_KEYS] = press_edges;
`ifdef IOB_RELEASE_EDGE_EN
        rdata_next[24 +: NUM_KEYS] = release_edges;
`endif
      end
      default: rdata_next = 32'd0;
    endcase
  end

  // Read data valid one cycle after avs_read, held otherwise
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= rdata_next;
    end else begin
      avs_readdata <= avs_readdata;
    end
  end

endmodule

// File: tb/tb_io_bridge_pio.sv
// Self-checking bench for io_bridge_pio (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8).
// Random FIFO traffic is checked against a queue model; debounce results
// are predicted from how long each key level is held.
module tb_io_bridge_pio;

  localparam int KW    = 8;
  localparam int HW    = 16;
  localparam int NK    = 2;
  localparam int DEPTH = 8;
  localparam int DB    = 4;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [1:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [NK-1:0] key_in;
  logic [KW-1:0] keycode_export;
  logic          keycode_valid;
  logic          keycode_ready;
  logic [HW-1:0] hex_digits_export;

  int n_cmp = 0;
  int n_bad = 0;

  logic [KW-1:0] kq[$];
  bit            m_ovf;
  bit            rel_en;

  io_bridge_pio #(
    .KEYCODE_W(KW), .HEX_W(HW), .NUM_KEYS(NK),
    .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .key_in(key_in), .keycode_export(keycode_export),
    .keycode_valid(keycode_valid), .keycode_ready(keycode_ready),
    .hex_digits_export(hex_digits_export)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'd0;
    s[15:8] = 8'(kq.size());
    s[2] = m_ovf;
    s[1] = (kq.size() == DEPTH);
    s[0] = (kq.size() == 0);
    return s;
  endfunction

  // One clock of FIFO traffic: optional push via addr0 and consumer ready.
  task automatic fifo_cycle(input bit do_push, input logic [31:0] data, input bit rdy);
    bit pop;
    avs_address = 2'd0; avs_writedata = data; avs_write = do_push;
    keycode_ready = rdy;
    check_eq("kc_valid", 32'(keycode_valid), 32'(kq.size() != 0));
    if (kq.size() != 0) check_eq("kc_head", 32'(keycode_export), 32'(kq[0]));
    pop = rdy && (kq.size() != 0);
    tick();
    if (pop) void'(kq.pop_front());
    if (do_push) begin
      if (kq.size() == DEPTH) m_ovf = 1'b1;
      else kq.push_back(data[KW-1:0]);
    end
    avs_write = 1'b0;
    keycode_ready = 1'b0;
  endtask

  task automatic hold_key(input int k, input logic lvl, input int n);
    key_in[k] = lvl;
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp;
    int len;
`ifdef IOB_RELEASE_EDGE_EN
    rel_en = 1'b1;
`else
    rel_en = 1'b0;
`endif
    reset_reset_n = 1'b0; avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'd0; key_in = '1; keycode_ready = 1'b0; m_ovf = 1'b0;
    repeat (3) tick();
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_valid", 32'(keycode_valid), 32'd0);
    check_eq("rst_export", 32'(keycode_export), 32'd0);
    check_eq("rst_hex", 32'(hex_digits_export), 32'd0);
    check_eq("rst_rdata", avs_readdata, 32'd0);

    // Release reset and write in the very first cycle: must be ignored
    reset_reset_n = 1'b1;
    wr(2'd2, 32'h0000_1234);
    check_eq("rel_cycle_hex", 32'(hex_digits_export), 32'd0);
    rd(2'd1, d); check_eq("status_reset", d, 32'h0000_0001);
    rd(2'd2, d); check_eq("hex_reset", d, 32'd0);

    // Directed FIFO: three codes, then drain
    fifo_cycle(1'b1, 32'h1A, 1'b0);
    fifo_cycle(1'b1, 32'h04, 1'b0);
    fifo_cycle(1'b1, 32'h16, 1'b0);
    rd(2'd1, d); check_eq("status_cnt3", d, 32'h0000_0300);
    rd(2'd0, d); check_eq("rd_head", d, 32'h0000_001A);
    check_eq("head_after_rd", 32'(keycode_export), 32'h1A);
    repeat (3) fifo_cycle(1'b0, 32'd0, 1'b1);
    check_eq("drained_valid", 32'(keycode_valid), 32'd0);

    // Overflow, clear, push+pop while full
    for (int i = 0; i < 9; i++) fifo_cycle(1'b1, 32'($urandom), 1'b0);
    rd(2'd1, d); check_eq("status_ovf", d, 32'h0000_0806);
    wr(2'd1, 32'h4); m_ovf = 1'b0;
    rd(2'd1, d); check_eq("status_ovf_clr", d, 32'h0000_0802);
    fifo_cycle(1'b1, 32'h5A, 1'b1);
    rd(2'd1, d); check_eq("status_pushpop_full", d, exp_status());
    check_eq("pushpop_cnt8", d, 32'h0000_0802);

    // Randomised FIFO traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      fifo_cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0));
      if (i % 25 == 24) begin
        rd(2'd1, d); check_eq("rand_status", d, exp_status());
        if (kq.size() != 0) begin
          rd(2'd0, d); check_eq("rand_head_rd", d, 32'(kq[0]));
        end
        if ($urandom_range(0, 1) == 1) begin
          wr(2'd1, 32'h4); m_ovf = 1'b0;
        end
      end
    end

    // Hex register
    wr(2'd2, 32'h0000_BEEF);
    check_eq("hex_export", 32'(hex_digits_export), 32'h0000_BEEF);
    wr(2'd2, 32'h1234_5678);
    check_eq("hex_trunc", 32'(hex_digits_export), 32'h0000_5678);
    rd(2'd2, d); check_eq("hex_rd", d, 32'h0000_5678);
    repeat (2) tick();
    check_eq("rdata_hold", avs_readdata, 32'h0000_5678);

    // Debounce: glitch shorter than DB, then a real press
    hold_key(0, 1'b0, DB - 1);
    hold_key(0, 1'b1, 10);
    rd(2'd3, d); check_eq("glitch_keys", d, 32'd0);
    hold_key(0, 1'b0, 10);
    rd(2'd3, d); check_eq("press_keys", d, 32'h0001_0001);
    check_eq("irq_masked", 32'(irq), 32'd0);
    wr(2'd3, 32'h0000_0100);
    tick();
    check_eq("irq_set", 32'(irq), 32'd1);
    rd(2'd3, d); check_eq("keys_mask", d, 32'h0001_0101);
    wr(2'd3, 32'h0001_0000);
    tick();
    check_eq("irq_clr", 32'(irq), 32'd0);
    rd(2'd3, d); check_eq("keys_w1c", d, 32'h0000_0001);
    hold_key(0, 1'b1, 10);
    exp = rel_en ? 32'h0100_0000 : 32'd0;
    rd(2'd3, d); check_eq("release_key0", d, exp);
    wr(2'd3, 32'hFFFF_0000);
    rd(2'd3, d); check_eq("keys_allclr", d, 32'd0);

    // Key1 press then release; mask 0x200 raises irq
    hold_key(1, 1'b0, 10);
    hold_key(1, 1'b1, 10);
    exp = rel_en ? 32'h0202_0000 : 32'h0002_0000;
    rd(2'd3, d); check_eq("key1_edges", d, exp);
    wr(2'd3, 32'h0000_0200);
    tick();
    check_eq("irq_key1", 32'(irq), 32'd1);
    wr(2'd3, 32'h0303_0000);
    tick();
    check_eq("irq_key1_clr", 32'(irq), 32'd0);

    // Random pulse lengths: edge iff the level is held for at least DB cycles
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 8);
      hold_key(1, 1'b0, len);
      hold_key(1, 1'b1, 12);
      exp = 32'd0;
      if (len >= DB) exp = rel_en ? 32'h0202_0000 : 32'h0002_0000;
      rd(2'd3, d); check_eq("rand_pulse", d, exp);
      wr(2'd3, 32'h0303_0000);
    end

    // Reset mid-transfer clears everything immediately
    fifo_cycle(1'b1, 32'h33, 1'b0);
    fifo_cycle(1'b1, 32'h44, 1'b0);
    keycode_ready = 1'b1;
    reset_reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(keycode_valid), 32'd0);
    check_eq("midrst_export", 32'(keycode_export), 32'd0);
    check_eq("midrst_hex", 32'(hex_digits_export), 32'd0);
    check_eq("midrst_rdata", avs_readdata, 32'd0);
    check_eq("midrst_irq", 32'(irq), 32'd0);
    keycode_ready = 1'b0;
    kq.delete(); m_ovf = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    tick();
    rd(2'd1, d); check_eq("post_rst_status", d, exp_status());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bridge_pio.md
Name: io_bridge_pio

Overview:
- Parametrised Avalon-MM slave peripheral that replaces the fixed-width keycode, hex-digit and key PIO exports of the game SoC.
- Software pushes USB keycodes into a FIFO. Game hardware pops them with a valid/ready handshake.
- Also drives the hex-digit export, and debounces NUM_KEYS push-buttons with edge capture and a maskable IRQ.

Parameters:
KEYCODE_W, 8, keycode width (1..32)
HEX_W, 16, hex_digits_export width (1..32)
NUM_KEYS, 2, number of push-buttons (1..8)
FIFO_DEPTH, 8, keycode FIFO entries; power of 2, 2..128
DEBOUNCE_CYCLES, 50000, stable cycles required before a key level is accepted (>=2)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  reset, asynchronous, active-low
avs_address  in  2  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, fixed read latency 1
irq  out  1  level interrupt
key_in  in  NUM_KEYS  raw buttons, asynchronous, active-low
keycode_export  out  KEYCODE_W  FIFO head
keycode_valid  out  1  FIFO non-empty
keycode_ready  in  1  consumer accepts head
hex_digits_export  out  HEX_W  hex display value

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0; FIFO empty; overflow=0; mask=0; edges=0; debounced levels=released; sync flops=1 (released); counters=0.
- Register map, read data zero-extended:
  - addr0 KEYCODE. Write pushes writedata[KEYCODE_W-1:0]. Read returns the FIFO head without popping.
  - addr1 STATUS. Read: [0] empty, [1] full, [2] overflow sticky, [15:8] count. Write: bit2=1 clears overflow.
  - addr2 HEX. R/W; hex_digits_export updates the cycle after the write.
  - addr3 KEYS. Read: [NUM_KEYS-1:0] debounced pressed, [8+:NUM_KEYS] irq mask, [16+:NUM_KEYS] press edges. Write: [8+] loads mask; [16+] write-1-to-clear edges.
- avs_readdata is registered: valid the cycle after avs_read; holds its last value otherwise.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit count.
  - Pop when keycode_valid && keycode_ready.
  - Push when full and no pop in the same cycle: data dropped, overflow=1, count unchanged.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push while empty: keycode_valid rises the next cycle. No bypass.
  - keycode_export equals the head whenever valid; it is don't-care but stable while empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Debounce, per key:
  - Two-flop synchroniser, then invert so pressed=1.
  - If synced != stable, the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable<=synced and the counter clears.
  - If synced == stable, the counter clears.
  - Latency from raw edge to stable change: 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Edge capture:
  - stable 0->1 sets edge[i].
  - If a set and a W1C land in the same cycle, set wins.
- irq is registered: irq <= |(edge & mask). It falls the cycle after clearing or masking.
- Writes to addresses 0..3 during the reset-release cycle are ignored.
- Reset assertion mid-operation discards FIFO contents immediately.

Optional Feature:
- Macro IOB_RELEASE_EDGE_EN.
- Defined:
  - addr3 read [24+:NUM_KEYS] holds release edges (stable 1->0); W1C via the same write bits.
  - irq <= |((press_edge|release_edge) & mask).
- Undefined:
  - Bits [31:24] read 0 and writes to them are ignored.
  - No release logic is synthesised.

Test Plan:
- Reset, then read addr1 -> 0x00000001 (empty). Read addr2 -> 0. irq=0, keycode_valid=0.
- Write 0x1A,0x04,0x16 to addr0, keycode_ready=0 -> count=3 and keycode_export=0x1A. Then keycode_ready=1 for 3 cycles -> outputs 0x1A,0x04,0x16, then valid=0.
- Defaults: push 9 codes with ready=0 -> status=0x0806 (count 8, full, overflow). Write addr1=0x4 -> overflow clears. Push+pop together while full -> count stays 8, overflow stays 0.
- DEBOUNCE_CYCLES=4: key_in[0] low for 3 cycles -> no change. Low for 10 cycles -> addr3 bit0=1 and bit16=1. Mask 0x100 -> irq=1 next cycle. Write 0x10000 -> irq=0 the following cycle.
- Write addr2=0xBEEF -> hex_digits_export=0xBEEF next cycle. Assert reset_reset_n=0 mid-FIFO-transfer -> all outputs 0 immediately.
- With IOB_RELEASE_EDGE_EN: press, then release key1 -> bits 17 and 25 set. Mask 0x200 -> irq=1. Without the macro, bit 25 reads 0.
